xf_write_arbiter: RTL and testbench
===================================

// Module: xf_write_arbiter
// PURPOSE
// - Shares the single XF register write bus between two requesters: the command processor's XF-load stream and host MMIO pokes.
// - Command-processor traffic arrives as multi-beat bursts; host traffic is single-beat.
// - Round-robin between requesters, with a bounded command-processor burst length so the host is never starved.
// - One registered output stage drives XFWrite/XFAddr/XFData toward the XF register file, which can stall via XFReady.
// PARAMETERS
// - ADDR_W        16   XF register address width.
// - DATA_W        32   XF write data width.
// - MAX_CP_BEATS  16   Max CP beats per grant while the host waits; matches the 4-bit XF-load size field.
// PORTS
// - clk           in   1       Clock; all logic is on the rising edge.
// - resetn        in   1       Reset: synchronous, active-low.
// - CPReqValid    in   1       CP beat valid.
// - CPReqReady    out  1       CP beat accepted this cycle.
// - CPReqAddr     in   ADDR_W  CP beat XF address; absolute per beat.
// - CPReqData     in   DATA_W  CP beat data.
// - CPReqLast     in   1       Final beat of a CP burst.
// - HostReqValid  in   1       Host write valid.
// - HostReqReady  out  1       Host write accepted this cycle.
// - HostReqAddr   in   ADDR_W  Host XF address.
// - HostReqData   in   DATA_W  Host write data.
// - XFWrite       out  1       XF write strobe (registered).
// - XFAddr        out  ADDR_W  XF write address (registered).
// - XFData        out  DATA_W  XF write data (registered).
// - XFReady       in   1       XF accepts the current beat when XFWrite=1.
// - ArbOwner      out  1       Current grant: 0=CP, 1=Host. Debug only.
// BEHAVIOUR
// - Reset values:
//   - XFWrite=0, XFAddr=0, XFData=0, ArbOwner=0, CPReqReady=0, HostReqReady=0.
//   - state=IDLE, lastOwner=HOST (so the CP wins the first tie), beatCnt=0.
// - Handshake:
//   - A beat transfers on a requester when Valid&&Ready are both 1.
//   - Once asserted, Valid must hold with stable addr/data until accepted. The bench flags violations.
// - Output stage is free when (!XFWrite || XFReady).
//   - Ready = (granted requester) && (output stage free). Ready is combinational from state and XFReady.
//   - An accepted beat loads the output register; XFWrite=1 on the next cycle (latency 1).
//   - If the output stage is free and nothing is accepted, XFWrite drops to 0.
//   - While XFWrite && !XFReady, XFAddr/XFData are held and both Readys are 0.
// - FSM states:
//   - IDLE: no grant.
//     - Both valid: grant goes to !lastOwner.
//     - One valid: grant goes to that requester.
//     - A grant moves to CP_BURST (beatCnt=0) or HOST. No beat is accepted in IDLE (1-cycle decision).
//   - CP_BURST: CPReqReady per the rule above; beatCnt increments (saturating) per accepted beat.
//     - On an accepted beat with CPReqLast: lastOwner=CP, go to IDLE.
//     - Else, when beatCnt reaches MAX_CP_BEATS and HostReqValid: lastOwner=CP, go to IDLE.
//       The unfinished CP burst resumes later with beatCnt cleared. No beat is lost; addresses are per-beat.
//     - If beatCnt==MAX_CP_BEATS and the host is idle: stay, beatCnt saturates.
//   - HOST: accept exactly one beat, then lastOwner=HOST and go to IDLE.
// - beatCnt width: $clog2(MAX_CP_BEATS+1).
// - ArbOwner = 1 only in HOST.
// - Reset mid-operation: the in-flight output beat is dropped (XFWrite=0 next cycle) and all state is cleared.
//   - The upstream requester retransmits.
// - Simultaneous events:
//   - Last-beat acceptance and preemption in the same cycle both return to IDLE; lastOwner=CP.
//   - A HostReqValid rising in the same cycle the CP burst ends is granted from IDLE next cycle.
// STRUCTURE
// - Shared package gx_bus_pkg holds:
//   - XF_ADDR_W and XF_DATA_W.
//   - Owner encoding (OWNER_CP=0, OWNER_HOST=1).
//   - Arbiter state encoding (IDLE, CP_BURST, HOST).
// - One sub-module: xf_out_stage, a 1-entry registered output with load/hold/drain driven by XFReady.
// - Top level contains the FSM, round-robin bit, beat counter and ready generation.
// TESTING
// - CP burst of 4 beats at 0x1000..0x1003 (last on the 4th), XFReady=1:
//   - XFWrite high 4 consecutive cycles, starting 2 cycles after CPReqValid rises.
//   - Addr/data appear in order.
// - CP and host both valid out of reset (host 0x2000/0xDEADBEEF):
//   - The full CP burst is written first, then the host write.
//   - ArbOwner=1 only during the HOST state.
// - CP 40-beat stream with no last, host valid at CP beat 3:
//   - Host write lands immediately after CP beat 16.
//   - CP then resumes at beat 17; all 40 CP beats are written exactly once.
// - XFReady=0 for 3 cycles mid-burst:
//   - XFAddr/XFData stable and CPReqReady=0 throughout.
//   - After release, no beat is duplicated or dropped.
// - resetn=0 for 1 cycle during a CP burst with XFWrite=1:
//   - Next cycle XFWrite=0, both Readys 0, state IDLE, lastOwner=HOST.
// - Host-only back-to-back writes to 0x3000 and 0x3001:
//   - One XF write every 2 cycles.
//   - CPReqReady stays 0 throughout.

Source files
------------

// File: rtl/gx_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gx_bus_pkg
// Summary  : Shared XF bus widths, owner encoding and arbiter state encoding.
// Revision : 1.0  initial release
// ============================================================================
package gx_bus_pkg;

  localparam int XF_ADDR_W = 16;
  localparam int XF_DATA_W = 32;

  localparam logic OWNER_CP   = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CP_BURST = 2'd1,
    ST_HOST     = 2'd2
  } arb_state_t;

  // On a tie the requester that did not own the bus last time wins.
  function automatic logic rr_pick(input logic cp_valid, input logic host_valid,
                                   input logic last_owner);
    if (cp_valid && host_valid) begin
      return ~last_owner;
    end
    return host_valid ? OWNER_HOST : OWNER_CP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : xf_write_arbiter_if
// Summary   : CP request, host request and XF write bus bundle.
// Revision  : 1.0  initial release
// ============================================================================
interface xf_write_arbiter_if
  import gx_bus_pkg::*;
#(
  parameter int ADDR_W = XF_ADDR_W,
  parameter int DATA_W = XF_DATA_W
) ();

  logic              CPReqValid;
  logic              CPReqReady;
  logic [ADDR_W-1:0] CPReqAddr;
  logic [DATA_W-1:0] CPReqData;
  logic              CPReqLast;

  logic              HostReqValid;
  logic              HostReqReady;
  logic [ADDR_W-1:0] HostReqAddr;
  logic [DATA_W-1:0] HostReqData;

  logic              XFWrite;
  logic [ADDR_W-1:0] XFAddr;
  logic [DATA_W-1:0] XFData;
  logic              XFReady;
  logic              ArbOwner;

  // Arbiter side.
  modport slave (
    input  CPReqValid, CPReqAddr, CPReqData, CPReqLast,
    input  HostReqValid, HostReqAddr, HostReqData,
    input  XFReady,
    output CPReqReady, HostReqReady,
    output XFWrite, XFAddr, XFData, ArbOwner
  );

  // Requester / register-file side.
  modport master (
    output CPReqValid, CPReqAddr, CPReqData, CPReqLast,
    output HostReqValid, HostReqAddr, HostReqData,
    output XFReady,
    input  CPReqReady, HostReqReady,
    input  XFWrite, XFAddr, XFData, ArbOwner
  );

endinterface
`default_nettype wire

// File: rtl/xf_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : xf_out_stage
// Summary  : One-entry registered XF write stage; loads when free, holds while
//            the register file stalls, drains to idle otherwise.
// Revision : 1.0  initial release
// ============================================================================
module xf_out_stage #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (free) begin
      valid <= load;
      if (load) begin
        addr <= load_addr;
        data <= load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xf_write_arbiter
// Summary  : Round-robin arbiter sharing the XF write bus between CP XF-load
//            bursts (length-bounded while the host waits) and host writes.
// Revision : 1.0  initial release
// ============================================================================
module xf_write_arbiter
  import gx_bus_pkg::*;
#(
  parameter int ADDR_W       = XF_ADDR_W,
  parameter int DATA_W       = XF_DATA_W,
  parameter int MAX_CP_BEATS = 16
) (
  input  logic              clk,
  input  logic              resetn,
  xf_write_arbiter_if.slave bus
);

  localparam int               CNT_W   = $clog2(MAX_CP_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CP_BEATS);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              last_owner_q;
  logic              last_owner_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  beat_cnt_d;
  logic [CNT_W-1:0]  cnt_after;

  logic              stage_free;
  logic              cp_ready;
  logic              host_ready;
  logic              cp_fire;
  logic              host_fire;
  logic              owner;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_HOST;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    cnt_after    = (cp_fire && (beat_cnt_q != MAX_CNT)) ? beat_cnt_q + 1'b1 : beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.CPReqValid || bus.HostReqValid) begin
          beat_cnt_d = '0;
          if (rr_pick(bus.CPReqValid, bus.HostReqValid, last_owner_q) == OWNER_HOST) begin
            state_d = ST_HOST;
          end else begin
            state_d = ST_CP_BURST;
          end
        end
      end
      ST_CP_BURST: begin
        beat_cnt_d = cnt_after;
        // Yielding mid-burst is safe: every beat carries its own address.
        if ((cp_fire && bus.CPReqLast) || ((cnt_after == MAX_CNT) && bus.HostReqValid)) begin
          state_d      = ST_IDLE;
          last_owner_d = OWNER_CP;
          beat_cnt_d   = '0;
        end
      end
      ST_HOST: begin
        if (host_fire) begin
          state_d      = ST_IDLE;
          last_owner_d = OWNER_HOST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cp_ready   = (state_q == ST_CP_BURST) && stage_free;
    host_ready = (state_q == ST_HOST) && stage_free;
    cp_fire    = cp_ready && bus.CPReqValid;
    host_fire  = host_ready && bus.HostReqValid;
    owner      = (state_q == ST_HOST) ? OWNER_HOST : OWNER_CP;
    load       = cp_fire || host_fire;
    load_addr  = host_fire ? bus.HostReqAddr : bus.CPReqAddr;
    load_data  = host_fire ? bus.HostReqData : bus.CPReqData;
  end

  assign bus.CPReqReady   = cp_ready;
  assign bus.HostReqReady = host_ready;
  assign bus.ArbOwner     = owner;

  xf_out_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .load_addr (load_addr),
    .load_data (load_data),
    .ready     (bus.XFReady),
    .valid     (bus.XFWrite),
    .addr      (bus.XFAddr),
    .data      (bus.XFData),
    .free      (stage_free)
  );

endmodule
`default_nettype wire

// File: tb/tb_xf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xf_write_arbiter
// Summary  : Self-checking bench for xf_write_arbiter with directed scenarios
//            and a randomized ordering/fairness scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_xf_write_arbiter;
  import gx_bus_pkg::*;

  localparam int MAXB = 16;
  localparam int TMO  = 300;

  typedef struct { logic [15:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  xf_write_arbiter_if bus ();

  xf_write_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (32),
    .MAX_CP_BEATS (MAXB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  wr_t obs[$];
  int hold_viol = 0;
  int stall_cycles = 0;
  int cp_ready_cnt = 0;
  int owner_cnt = 0;
  int owner_viol = 0;
  bit prev_stall = 1'b0;
  logic [15:0] p_addr;
  logic [31:0] p_data;
  bit abort = 1'b0;
  int cp_sent = 0;

  always @(posedge clk) cyc++;

  // Passive monitor: record completed XF writes and track stall/owner rules.
  always @(negedge clk) begin
    if (resetn) begin
      wr_t w;
      if (prev_stall && (!bus.XFWrite || bus.XFAddr !== p_addr || bus.XFData !== p_data))
        hold_viol++;
      if (bus.XFWrite && !bus.XFReady) begin
        stall_cycles++;
        if (bus.CPReqReady || bus.HostReqReady) hold_viol++;
      end
      if (bus.XFWrite && bus.XFReady) begin
        w.addr = bus.XFAddr; w.data = bus.XFData; w.cyc = cyc;
        obs.push_back(w);
      end
      if (bus.CPReqReady) cp_ready_cnt++;
      if (bus.ArbOwner) owner_cnt++;
      if ((bus.HostReqReady && !bus.ArbOwner) || (bus.CPReqReady && bus.ArbOwner)) owner_viol++;
      prev_stall = bus.XFWrite && !bus.XFReady;
      p_addr = bus.XFAddr;
      p_data = bus.XFData;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    abort = 1'b0;
    bus.CPReqValid = 1'b0; bus.CPReqAddr = '0; bus.CPReqData = '0; bus.CPReqLast = 1'b0;
    bus.HostReqValid = 1'b0; bus.HostReqAddr = '0; bus.HostReqData = '0;
    bus.XFReady = 1'b1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic cp_send(input int n, input logic [15:0] base, input logic [31:0] seed,
                         input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t;
      if (abort) break;
      bus.CPReqValid = 1'b1;
      bus.CPReqAddr  = base + 16'(i);
      bus.CPReqData  = seed + 32'(i);
      bus.CPReqLast  = with_last && (i == n - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!abort && !bus.CPReqReady && t < TMO);
      if (abort) break;
      if (!bus.CPReqReady) begin
        tests++; fails++;
        $display("FAIL cp_handshake_timeout beat=%0d got=no_ready required=ready", i);
        break;
      end
      @(posedge clk); #1;
      cp_sent++;
    end
    bus.CPReqValid = 1'b0;
    bus.CPReqLast  = 1'b0;
  endtask

  task automatic host_send(input logic [15:0] a, input logic [31:0] d);
    int t;
    bus.HostReqValid = 1'b1;
    bus.HostReqAddr  = a;
    bus.HostReqData  = d;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.HostReqReady && t < TMO);
    if (!bus.HostReqReady) begin
      tests++; fails++;
      $display("FAIL host_handshake_timeout addr=%h got=no_ready required=ready", a);
    end else begin
      @(posedge clk); #1;
    end
    bus.HostReqValid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({bus.XFWrite, bus.ArbOwner, bus.CPReqReady, bus.HostReqReady} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got=%b required=0000",
               {bus.XFWrite, bus.ArbOwner, bus.CPReqReady, bus.HostReqReady});
    end
    tests++;
    if (bus.XFAddr !== 16'h0 || bus.XFData !== 32'h0) begin
      fails++; $display("FAIL reset_addr_data got=%h/%h required=0/0", bus.XFAddr, bus.XFData);
    end
    tests++;
    if (dut.state_q !== ST_IDLE || dut.last_owner_q !== OWNER_HOST || dut.beat_cnt_q !== '0) begin
      fails++;
      $display("FAIL reset_state got=%0d/%b/%0d required=IDLE/HOST/0",
               dut.state_q, dut.last_owner_q, dut.beat_cnt_q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cp_burst();
    int start, s;
    do_reset();
    start = obs.size();
    s = cyc;
    cp_send(4, 16'h1000, 32'hA500_0000, 1'b1);
    repeat (4) @(posedge clk); #1;
    tests++;
    if (obs.size() - start != 4) begin
      fails++; $display("FAIL cp_burst_count got=%0d required=4", obs.size() - start);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (start + k >= obs.size()) begin
        fails++; $display("FAIL cp_burst_beat%0d got=missing required=present", k);
      end else if (obs[start+k].addr !== 16'h1000 + 16'(k) ||
                   obs[start+k].data !== 32'hA500_0000 + 32'(k) ||
                   obs[start+k].cyc != s + 2 + k) begin
        fails++;
        $display("FAIL cp_burst_beat%0d got=%h/%h@%0d required=%h/%h@%0d", k,
                 obs[start+k].addr, obs[start+k].data, obs[start+k].cyc - s,
                 16'h1000 + 16'(k), 32'hA500_0000 + 32'(k), 2 + k);
      end
    end
  endtask

  task automatic test_both_valid();
    beat_t exp[$];
    beat_t e;
    int start, oc0, ov0;
    do_reset();
    start = obs.size(); oc0 = owner_cnt; ov0 = owner_viol;
    for (int i = 0; i < 4; i++) begin
      e.addr = 16'h1100 + 16'(i); e.data = 32'h1234_0000 + 32'(i); exp.push_back(e);
    end
    e.addr = 16'h2000; e.data = 32'hDEAD_BEEF; exp.push_back(e);
    fork
      cp_send(4, 16'h1100, 32'h1234_0000, 1'b1);
      host_send(16'h2000, 32'hDEAD_BEEF);
    join
    repeat (4) @(posedge clk); #1;
    tests++;
    if (obs.size() - start != 5) begin
      fails++; $display("FAIL both_count got=%0d required=5", obs.size() - start);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (start + k >= obs.size() || obs[start+k].addr !== exp[k].addr ||
          obs[start+k].data !== exp[k].data) begin
        fails++;
        $display("FAIL both_order[%0d] got=%h/%h required=%h/%h", k,
                 (start + k < obs.size()) ? obs[start+k].addr : 16'hxxxx,
                 (start + k < obs.size()) ? obs[start+k].data : 32'hxxxx_xxxx,
                 exp[k].addr, exp[k].data);
      end
    end
    tests++;
    if (owner_cnt - oc0 != 1 || owner_viol != ov0) begin
      fails++;
      $display("FAIL both_owner got=cycles:%0d viol:%0d required=cycles:1 viol:0",
               owner_cnt - oc0, owner_viol - ov0);
    end
  endtask

  task automatic test_preempt();
    beat_t exp[$];
    beat_t e;
    int start;
    do_reset();
    start = obs.size();
    cp_sent = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == MAXB) begin e.addr = 16'h2100; e.data = 32'hCAFE_0001; exp.push_back(e); end
      e.addr = 16'h4000 + 16'(i); e.data = 32'h5000_0000 + 32'(i); exp.push_back(e);
    end
    fork
      cp_send(40, 16'h4000, 32'h5000_0000, 1'b0);
      begin
        int t;
        t = 0;
        while (cp_sent < 3 && t < TMO) begin @(posedge clk); #2; t++; end
        host_send(16'h2100, 32'hCAFE_0001);
      end
    join
    repeat (4) @(posedge clk); #1;
    tests++;
    if (obs.size() - start != 41) begin
      fails++; $display("FAIL preempt_count got=%0d required=41", obs.size() - start);
    end
    for (int k = 0; k < 41; k++) begin
      tests++;
      if (start + k >= obs.size() || obs[start+k].addr !== exp[k].addr ||
          obs[start+k].data !== exp[k].data) begin
        fails++;
        $display("FAIL preempt_order[%0d] got=%h/%h required=%h/%h", k,
                 (start + k < obs.size()) ? obs[start+k].addr : 16'hxxxx,
                 (start + k < obs.size()) ? obs[start+k].data : 32'hxxxx_xxxx,
                 exp[k].addr, exp[k].data);
      end
    end
  endtask

  task automatic test_stall();
    int start, hv0, sc0;
    do_reset();
    start = obs.size(); hv0 = hold_viol; sc0 = stall_cycles;
    fork
      cp_send(8, 16'h1200, 32'h7700_0000, 1'b1);
      begin
        int t;
        t = 0;
        while (obs.size() < start + 3 && t < TMO) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1 bus.XFReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.XFReady = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    tests++;
    if (stall_cycles - sc0 != 3 || hold_viol != hv0) begin
      fails++;
      $display("FAIL stall_hold got=stalls:%0d viol:%0d required=stalls:3 viol:0",
               stall_cycles - sc0, hold_viol - hv0);
    end
    tests++;
    if (obs.size() - start != 8) begin
      fails++; $display("FAIL stall_count got=%0d required=8", obs.size() - start);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (start + k >= obs.size() || obs[start+k].addr !== 16'h1200 + 16'(k) ||
          obs[start+k].data !== 32'h7700_0000 + 32'(k)) begin
        fails++;
        $display("FAIL stall_order[%0d] got=%h required=%h", k,
                 (start + k < obs.size()) ? obs[start+k].addr : 16'hxxxx, 16'h1200 + 16'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic wr_before;
    int start;
    do_reset();
    start = obs.size();
    wr_before = 1'b0;
    fork
      cp_send(8, 16'h1300, 32'h3300_0000, 1'b1);
      begin
        int t;
        t = 0;
        while (obs.size() < start + 2 && t < TMO) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        wr_before = bus.XFWrite;
        abort = 1'b1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
      end
    join
    abort = 1'b0;
    tests++;
    if (wr_before !== 1'b1) begin
      fails++; $display("FAIL reset_mid_inflight got=%b required=1", wr_before);
    end
    tests++;
    if ({bus.XFWrite, bus.CPReqReady, bus.HostReqReady} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_outputs got=%b required=000",
               {bus.XFWrite, bus.CPReqReady, bus.HostReqReady});
    end
    tests++;
    if (dut.state_q !== ST_IDLE || dut.last_owner_q !== OWNER_HOST) begin
      fails++;
      $display("FAIL reset_mid_state got=%0d/%b required=IDLE/HOST", dut.state_q, dut.last_owner_q);
    end
  endtask

  task automatic test_back_to_back_host();
    int start, s, cr0;
    do_reset();
    start = obs.size(); cr0 = cp_ready_cnt; s = cyc;
    host_send(16'h3000, 32'h0000_3000);
    host_send(16'h3001, 32'h0000_3001);
    repeat (4) @(posedge clk); #1;
    tests++;
    if (obs.size() - start != 2) begin
      fails++; $display("FAIL host_b2b_count got=%0d required=2", obs.size() - start);
    end else begin
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs[start+k].addr !== 16'h3000 + 16'(k) || obs[start+k].data !== 32'h3000 + 32'(k) ||
            obs[start+k].cyc != s + 2 + 2 * k) begin
          fails++;
          $display("FAIL host_b2b[%0d] got=%h@%0d required=%h@%0d", k, obs[start+k].addr,
                   obs[start+k].cyc - s, 16'h3000 + 16'(k), 2 + 2 * k);
        end
      end
    end
    tests++;
    if (cp_ready_cnt != cr0) begin
      fails++; $display("FAIL host_b2b_cpready got=%0d required=0", cp_ready_cnt - cr0);
    end
  endtask

  task automatic test_random();
    beat_t exp_cp[$];
    beat_t exp_host[$];
    int hrise[$];
    int start, ci, hi, hv0, ov0;
    bit cp_done, host_done;
    do_reset();
    start = obs.size(); hv0 = hold_viol; ov0 = owner_viol;
    cp_done = 1'b0; host_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          int len;
          logic [15:0] base;
          logic [31:0] seed;
          beat_t e;
          len  = $urandom_range(1, 24);
          base = 16'(b * 64);
          seed = $urandom;
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          for (int i = 0; i < len; i++) begin
            e.addr = base + 16'(i); e.data = seed + 32'(i); exp_cp.push_back(e);
          end
          cp_send(len, base, seed, 1'b1);
        end
        cp_done = 1'b1;
      end
      begin
        for (int h = 0; h < 8; h++) begin
          beat_t e;
          repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
          e.addr = 16'h8000 | 16'(h); e.data = $urandom;
          exp_host.push_back(e);
          hrise.push_back(obs.size());
          host_send(e.addr, e.data);
        end
        host_done = 1'b1;
      end
      begin
        while (!(cp_done && host_done)) begin
          @(posedge clk); #1;
          bus.XFReady = ($urandom_range(0, 3) != 0);
        end
        bus.XFReady = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    ci = 0; hi = 0;
    for (int j = start; j < obs.size(); j++) begin
      if (obs[j].addr[15]) begin
        int ncp;
        tests++;
        if (hi >= exp_host.size() || obs[j].addr !== exp_host[hi].addr ||
            obs[j].data !== exp_host[hi].data) begin
          fails++;
          $display("FAIL rand_host[%0d] got=%h/%h required=%h/%h", hi, obs[j].addr, obs[j].data,
                   (hi < exp_host.size()) ? exp_host[hi].addr : 16'hxxxx,
                   (hi < exp_host.size()) ? exp_host[hi].data : 32'hxxxx_xxxx);
        end
        ncp = 0;
        if (hi < hrise.size())
          for (int m = hrise[hi]; m < j; m++) if (!obs[m].addr[15]) ncp++;
        tests++;
        if (ncp > MAXB + 1) begin
          fails++; $display("FAIL rand_fairness[%0d] got=%0d cp beats required<=%0d", hi, ncp, MAXB + 1);
        end
        hi++;
      end else begin
        tests++;
        if (ci >= exp_cp.size() || obs[j].addr !== exp_cp[ci].addr || obs[j].data !== exp_cp[ci].data) begin
          fails++;
          $display("FAIL rand_cp[%0d] got=%h/%h required=%h/%h", ci, obs[j].addr, obs[j].data,
                   (ci < exp_cp.size()) ? exp_cp[ci].addr : 16'hxxxx,
                   (ci < exp_cp.size()) ? exp_cp[ci].data : 32'hxxxx_xxxx);
        end
        ci++;
      end
    end
    tests++;
    if (ci != exp_cp.size() || hi != exp_host.size()) begin
      fails++;
      $display("FAIL rand_totals got=cp:%0d host:%0d required=cp:%0d host:%0d",
               ci, hi, exp_cp.size(), exp_host.size());
    end
    tests++;
    if (hold_viol != hv0 || owner_viol != ov0) begin
      fails++;
      $display("FAIL rand_rules got=hold:%0d owner:%0d required=0/0", hold_viol - hv0, owner_viol - ov0);
    end
  endtask

  initial begin
    test_reset();
    test_cp_burst();
    test_both_valid();
    test_preempt();
    test_stall();
    test_reset_mid();
    test_back_to_back_host();
    for (int r = 0; r < 3; r++) test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
